// File: rtl/pong_graph_anim.sv
// rtl/pong_graph_anim.sv - pong ball/paddle animation and pixel colouring; optional round ball via ROUND_BALL_EN
module pong_graph_anim #(
    parameter int H_MAX       = 640,
    parameter int V_MAX       = 480,
    parameter int BALL_SIZE   = 8,
    parameter int BALL_V      = 2,
    parameter int BAR_H       = 72,
    parameter int BAR_V       = 4,
    parameter int MISS_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        start,
    output logic [11:0] rgb,
    output logic        hit,
    output logic        miss
);

    localparam int CNT_W = (MISS_FRAMES < 2) ? 1 : $clog2(MISS_FRAMES);

    localparam logic [9:0] WALL_L      = 10'd32;
    localparam logic [9:0] WALL_R      = 10'd35;
    localparam logic [9:0] TOP_B       = 10'd5;
    localparam logic [9:0] BOT_T       = 10'd475;
    localparam logic [9:0] BOT_B       = 10'd479;
    localparam logic [9:0] BAR_L       = 10'd600;
    localparam logic [9:0] BAR_R       = 10'd603;
    localparam logic [9:0] PLAY_TOP    = 10'd6;
    localparam logic [9:0] PLAY_BOT    = 10'd474;
    localparam logic [9:0] LEFT_BOUNCE = 10'd36;
    localparam logic [9:0] BAR_TOP     = 10'd6;
    localparam logic [9:0] BAR_BOT     = 10'(474 - BAR_H);
    localparam logic [9:0] BAR_STEP    = 10'(BAR_V);
    localparam logic [9:0] BAR_UP_MIN  = 10'(6 + BAR_V);
    localparam logic [9:0] BAR_SPAN    = 10'(BAR_H - 1);
    localparam logic [9:0] BAR_Y0      = 10'((V_MAX - BAR_H) / 2);
    localparam logic [9:0] BALL_X0     = 10'((H_MAX - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0     = 10'((V_MAX - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_SPAN   = 10'(BALL_SIZE - 1);
    localparam logic [9:0] VEL_POS     = 10'(BALL_V);
    localparam logic [9:0] VEL_NEG     = 10'(-BALL_V);
    localparam logic [9:0] X_LAST      = 10'(H_MAX - 1);
    localparam logic [9:0] REFR_ROW    = 10'(V_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PLAY      = 2'd1,
        S_MISS_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        ball_x_q, ball_x_d;
    logic [9:0]        ball_y_q, ball_y_d;
    logic [9:0]        dx_q, dx_d;
    logic [9:0]        dy_q, dy_d;
    logic [9:0]        bar_y_q, bar_y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;

    logic              refr_tick;
    logic [9:0]        ball_r, ball_b, bar_b;
    logic [9:0]        dx_n, dy_n;
    logic              bar_hit, ball_out;
    logic              wall_on, bar_on, box_on, ball_px;

    assign refr_tick = (pixel_x == 10'd0) && (pixel_y == REFR_ROW);
    assign ball_r    = ball_x_q + BALL_SPAN;
    assign ball_b    = ball_y_q + BALL_SPAN;
    assign bar_b     = bar_y_q + BAR_SPAN;
    assign ball_out  = ball_r > X_LAST;
    // Only a ball travelling right can be returned, so it cannot be hit twice on its way out
    assign bar_hit   = !dx_q[9] && (ball_r >= BAR_L) && (ball_r <= BAR_R) &&
                       (ball_y_q <= bar_b) && (ball_b >= bar_y_q);

    // Per-frame motion: paddle, ball bounce/move, serve and miss sequencing
    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        bar_y_d  = bar_y_q;
        cnt_d    = cnt_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        dx_n     = dx_q;
        dy_n     = dy_q;
        if (refr_tick) begin
            if (btn_up && !btn_down) begin
                bar_y_d = (bar_y_q < BAR_UP_MIN) ? BAR_TOP : bar_y_q - BAR_STEP;
            end else if (btn_down && !btn_up) begin
                bar_y_d = (bar_y_q + BAR_STEP > BAR_BOT) ? BAR_BOT : bar_y_q + BAR_STEP;
            end
            case (state_q)
                S_IDLE: begin
                    ball_x_d = BALL_X0;
                    ball_y_d = BALL_Y0;
                    dx_d     = VEL_NEG;
                    dy_d     = VEL_POS;
                    if (start) begin
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (ball_out) begin
                        miss_d  = 1'b1;
                        state_d = S_MISS_WAIT;
                        cnt_d   = '0;
                    end else begin
                        if (ball_y_q <= PLAY_TOP) dy_n = VEL_POS;
                        if (ball_b >= PLAY_BOT)   dy_n = VEL_NEG;
                        if (ball_x_q <= LEFT_BOUNCE) dx_n = VEL_POS;
                        if (bar_hit) begin
                            dx_n  = VEL_NEG;
                            hit_d = 1'b1;
                        end
                        dx_d     = dx_n;
                        dy_d     = dy_n;
                        ball_x_d = ball_x_q + dx_n;
                        ball_y_d = ball_y_q + dy_n;
                    end
                end
                S_MISS_WAIT: begin
                    if (cnt_q == CNT_W'(MISS_FRAMES - 1)) begin
                        state_d  = S_IDLE;
                        cnt_d    = '0;
                        ball_x_d = BALL_X0;
                        ball_y_d = BALL_Y0;
                        dx_d     = VEL_NEG;
                        dy_d     = VEL_POS;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

`ifdef ROUND_BALL_EN
    logic [2:0] rel_x, rel_y;
    logic [7:0] rom_row;

    // Circle ROM lookup; low bits of the pixel offset inside the ball box select row and column
    always_comb begin
        rel_x = pixel_x[2:0] - ball_x_q[2:0];
        rel_y = pixel_y[2:0] - ball_y_q[2:0];
        case (rel_y)
            3'd0:    rom_row = 8'h3C;
            3'd1:    rom_row = 8'h7E;
            3'd2:    rom_row = 8'hFF;
            3'd3:    rom_row = 8'hFF;
            3'd4:    rom_row = 8'hFF;
            3'd5:    rom_row = 8'hFF;
            3'd6:    rom_row = 8'h7E;
            default: rom_row = 8'h3C;
        endcase
        ball_px = rom_row[3'd7 - rel_x];
    end
`else
    assign ball_px = 1'b1;
`endif

    // Pixel colour with wall > paddle > ball > background priority, blanked outside the visible area
    always_comb begin
        wall_on = ((pixel_x >= WALL_L) && (pixel_x <= WALL_R)) ||
                  (pixel_y <= TOP_B) ||
                  ((pixel_y >= BOT_T) && (pixel_y <= BOT_B));
        bar_on  = (pixel_x >= BAR_L) && (pixel_x <= BAR_R) &&
                  (pixel_y >= bar_y_q) && (pixel_y <= bar_b);
        box_on  = (state_q != S_MISS_WAIT) &&
                  (pixel_x >= ball_x_q) && (pixel_x <= ball_r) &&
                  (pixel_y >= ball_y_q) && (pixel_y <= ball_b);
        rgb_d   = 12'h000;
        if (video_on) begin
            if (wall_on)                rgb_d = 12'h00F;
            else if (bar_on)            rgb_d = 12'h0F0;
            else if (box_on && ball_px) rgb_d = 12'hF00;
            else                        rgb_d = 12'h0FF;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ball_x_q <= BALL_X0;
            ball_y_q <= BALL_Y0;
            dx_q     <= VEL_NEG;
            dy_q     <= VEL_POS;
            bar_y_q  <= BAR_Y0;
            cnt_q    <= '0;
            rgb_q    <= 12'h000;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            bar_y_q  <= bar_y_d;
            cnt_q    <= cnt_d;
            rgb_q    <= rgb_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign rgb  = rgb_q;
    assign hit  = hit_q;
    assign miss = miss_q;

endmodule

// File: tb/tb_pong_graph_anim.sv
// tb/tb_pong_graph_anim.sv - randomized model-checked bench for pong_graph_anim (honours ROUND_BALL_EN)
module tb_pong_graph_anim;

    localparam int H = 640, V = 480, S = 8, BV = 2, BH = 72, BARV = 4, MF = 60;
    localparam int CH = 1016, CV = 932;

    typedef struct {
        int st;   // 0 idle, 1 play, 2 miss wait
        int bx;
        int by;
        int dx;
        int dy;
        int bar;
        int cnt;
    } mdl_t;

    logic        clk, reset_n, video_on;
    logic [9:0]  pixel_x, pixel_y;
    logic        btn_up, btn_down, start;
    logic [11:0] rgb;
    logic        hit, miss;

    logic [9:0]  c_pixel_x, c_pixel_y;
    logic        c_start, c_zero;
    logic [11:0] c_rgb;
    logic        c_hit, c_miss;

    int   checks = 0, errors = 0;
    int   bar_min = 1023;
    int   mh = 0, mm = 0;
    mdl_t m, mc;

    pong_graph_anim dut (
        .clk(clk), .reset_n(reset_n), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .btn_up(btn_up), .btn_down(btn_down), .start(start),
        .rgb(rgb), .hit(hit), .miss(miss)
    );

    pong_graph_anim #(.H_MAX(CH), .V_MAX(CV)) dut_c (
        .clk(clk), .reset_n(reset_n), .video_on(video_on),
        .pixel_x(c_pixel_x), .pixel_y(c_pixel_y),
        .btn_up(c_zero), .btn_down(c_zero), .start(c_start),
        .rgb(c_rgb), .hit(c_hit), .miss(c_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mreset(input int h, input int v);
        mdl_t s;
        s.st = 0; s.bx = (h - S) / 2; s.by = (v - S) / 2;
        s.dx = -BV; s.dy = BV; s.bar = (v - BH) / 2; s.cnt = 0;
        return s;
    endfunction

    // One clock of game rules applied to the model
    task automatic mstep(inout mdl_t s, input int h, input int v, input bit tick,
                         input bit up, input bit dn, input bit st,
                         output bit ph, output bit pm);
        int ob, right, ndx, ndy;
        ph = 0; pm = 0;
        if (!tick) return;
        ob = s.bar;
        if (up && !dn)      s.bar = (ob - BARV < 6) ? 6 : ob - BARV;
        else if (dn && !up) s.bar = (ob + BARV > 474 - BH) ? 474 - BH : ob + BARV;
        case (s.st)
            0: begin
                s.bx = (h - S) / 2; s.by = (v - S) / 2; s.dx = -BV; s.dy = BV;
                if (st) s.st = 1;
            end
            1: begin
                right = s.bx + S - 1;
                if (right > h - 1) begin
                    pm = 1; s.st = 2; s.cnt = 0;
                end else begin
                    ndx = s.dx; ndy = s.dy;
                    if (s.by <= 6) ndy = BV;
                    if (s.by + S - 1 >= 474) ndy = -BV;
                    if (s.bx <= 36) ndx = BV;
                    if (s.dx > 0 && right >= 600 && right <= 603 &&
                        s.by <= ob + BH - 1 && s.by + S - 1 >= ob) begin
                        ndx = -BV; ph = 1;
                    end
                    s.dx = ndx; s.dy = ndy;
                    s.bx = (s.bx + ndx) & 1023;
                    s.by = (s.by + ndy) & 1023;
                end
            end
            default: begin
                s.cnt++;
                if (s.cnt == MF) begin
                    s.st = 0; s.cnt = 0;
                    s.bx = (h - S) / 2; s.by = (v - S) / 2; s.dx = -BV; s.dy = BV;
                end
            end
        endcase
    endtask

    function automatic int colour(input mdl_t s, input int x, input int y, input bit von);
        int rom[8] = '{'h3C, 'h7E, 'hFF, 'hFF, 'hFF, 'hFF, 'h7E, 'h3C};
        if (!von) return 'h000;
        if ((x >= 32 && x <= 35) || y <= 5 || (y >= 475 && y <= 479)) return 'h00F;
        if (x >= 600 && x <= 603 && y >= s.bar && y <= s.bar + BH - 1) return 'h0F0;
        if (s.st != 2 && x >= s.bx && x < s.bx + S && y >= s.by && y < s.by + S) begin
`ifdef ROUND_BALL_EN
            if (((rom[y - s.by] >> (7 - (x - s.bx))) & 1) == 1) return 'hF00;
            return 'h0FF;
`else
            if (rom[0] != 0) return 'hF00;
`endif
        end
        return 'h0FF;
    endfunction

    // Drive one clock of main-DUT stimulus, advance the model, compare after the edge
    task automatic cyc(input bit tick, input bit von, input int px, input int py,
                       input bit up, input bit dn, input bit st);
        int  erg;
        bit  eh, em;
        if (tick) begin px = 0; py = V + 1; end
        video_on = von; pixel_x = 10'(px); pixel_y = 10'(py);
        btn_up = up; btn_down = dn; start = st;
        erg = colour(m, px, py, von);
        mstep(m, H, V, tick, up, dn, st, eh, em);
        if (eh) mh++;
        if (em) mm++;
        @(posedge clk); #1;
        chk("rgb", int'(rgb), erg);
        chk("hit", int'(hit), int'(eh));
        chk("miss", int'(miss), int'(em));
        chk("ball_x", int'(dut.ball_x_q), m.bx);
        chk("ball_y", int'(dut.ball_y_q), m.by);
        chk("bar_y", int'(dut.bar_y_q), m.bar);
        if (int'(dut.bar_y_q) < bar_min) bar_min = int'(dut.bar_y_q);
        if (hit) chk("dx_after_hit", int'(dut.dx_q), 1022);
    endtask

    task automatic frame(input bit up, input bit dn, input bit st);
        int px, py;
        for (int i = 0; i < 3; i++) begin
            case ($urandom % 4)
                0: begin px = m.bx - 2 + int'($urandom % 12); py = m.by - 2 + int'($urandom % 12); end
                1: begin px = 598 + int'($urandom % 8); py = m.bar - 2 + int'($urandom % (BH + 4)); end
                2: begin px = 30 + int'($urandom % 8); py = int'($urandom % 480); end
                default: begin px = int'($urandom % 640); py = int'($urandom % 480); end
            endcase
            px = px & 1023; py = py & 1023;
            if (px == 0 && py == V + 1) px = 1;
            cyc(0, ($urandom % 8) != 0, px, py, $urandom % 2, $urandom % 2, $urandom % 2);
        end
        cyc(1, $urandom % 2, 0, 0, up, dn, st);
    endtask

    task automatic ctick(input bit st);
        bit eh, em;
        c_pixel_x = 10'd0; c_pixel_y = 10'(CV + 1); c_start = st;
        mstep(mc, CH, CV, 1, 0, 0, st, eh, em);
        @(posedge clk); #1;
        chk("c_ball_x", int'(dut_c.ball_x_q), mc.bx);
        chk("c_ball_y", int'(dut_c.ball_y_q), mc.by);
        chk("c_hit", int'(c_hit), int'(eh));
        chk("c_miss", int'(c_miss), int'(em));
        c_pixel_y = 10'd0; c_start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int px, c, p, f;
        reset_n = 1'b0; video_on = 1'b1; pixel_x = 10'd1; pixel_y = 10'd0;
        btn_up = 0; btn_down = 0; start = 0;
        c_pixel_x = 10'd1; c_pixel_y = 10'd0; c_start = 0; c_zero = 0;
        #3;
        chk("reset_rgb_noclk", int'(rgb), 0);
        chk("reset_hit", int'(hit), 0);
        chk("reset_miss", int'(miss), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rgb", int'(rgb), 0);
        chk("reset_bar", int'(dut.bar_y_q), 204);
        chk("reset_ball_x", int'(dut.ball_x_q), 316);
        chk("reset_ball_y", int'(dut.ball_y_q), 236);
        reset_n = 1'b1;
        m = mreset(H, V); mc = mreset(CH, CV);

        cyc(0, 1, 33, 200, 0, 0, 0); chk("wall_pixel", int'(rgb), 'h00F);
        cyc(0, 0, 33, 200, 0, 0, 0); chk("blank_pixel", int'(rgb), 'h000);
`ifdef ROUND_BALL_EN
        cyc(0, 1, 316, 236, 0, 0, 0); chk("round_corner", int'(rgb), 'h0FF);
        cyc(0, 1, 319, 239, 0, 0, 0); chk("round_centre", int'(rgb), 'hF00);
`else
        cyc(0, 1, 316, 236, 0, 0, 0); chk("square_corner", int'(rgb), 'hF00);
`endif

        // paddle saturation and both-button hold
        bar_min = 1023;
        repeat (100) frame(1, 0, 0);
        chk("bar_sat_top", int'(dut.bar_y_q), 6);
        chk("bar_min", bar_min, 6);
        repeat (3) frame(0, 1, 0);
        chk("bar_down3", int'(dut.bar_y_q), 18);
        repeat (3) frame(1, 1, 0);
        chk("bar_both_hold", int'(dut.bar_y_q), 18);

        // serve and travel to the left wall
        frame(0, 0, 1);
        chk("serve_x", int'(dut.ball_x_q), 316);
        frame(0, 0, 0);
        chk("first_move_x", int'(dut.ball_x_q), 314);
        repeat (139) frame($urandom % 2, $urandom % 2, 0);
        chk("left_reach_x", int'(dut.ball_x_q), 36);
        frame(0, 0, 0);
        chk("left_bounce_x", int'(dut.ball_x_q), 38);
        chk("left_bounce_dx", int'(dut.dx_q), 2);

        // paddle tracks the ball until it has been returned twice
        for (f = 0; f < 3000 && mh < 2; f++) begin
            c = m.by + 4; p = m.bar + 36;
            frame(p > c + 2, p < c - 2, 0);
        end
        chk("hits_reached", int'(mh >= 2), 1);

        // paddle moves away until the ball is missed
        for (f = 0; f < 3000 && mm < 1; f++) begin
            c = m.by + 4;
            frame(c >= 240, c < 240, 0);
        end
        chk("miss_reached", int'(mm >= 1), 1);
        cyc(0, 1, m.bx + 3, m.by + 3, 0, 0, 1);
        chk("ball_hidden", int'(rgb), 'h0FF);
        repeat (59) frame($urandom % 2, $urandom % 2, 1);
        cyc(0, 1, m.bx + 3, m.by + 3, 0, 0, 1);
        chk("ball_hidden_59", int'(rgb), 'h0FF);
        frame(0, 0, 1);
        chk("recentre_x", int'(dut.ball_x_q), 316);
        chk("recentre_y", int'(dut.ball_y_q), 236);
        cyc(0, 1, 319, 239, 0, 0, 0);
        chk("recentre_visible", int'(rgb), 'hF00);

        // free random play
        repeat (300) frame($urandom % 2, $urandom % 2, ($urandom % 4) == 0);

        // asynchronous reset in the middle of play
        for (f = 0; f < 200 && m.st != 1; f++) frame(0, 0, 1);
        chk("in_play", m.st, 1);
        frame(0, 0, 0);
        px = (m.bx < 300) ? 450 : 100;
        cyc(0, 1, px, 300, 0, 0, 0);
        chk("pre_reset_rgb", int'(rgb), 'h0FF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rgb", int'(rgb), 0);
        chk("async_hit", int'(hit), 0);
        chk("async_miss", int'(miss), 0);
        chk("async_ball_x", int'(dut.ball_x_q), 316);
        chk("async_ball_y", int'(dut.ball_y_q), 236);
        chk("async_bar", int'(dut.bar_y_q), 204);
        chk("async_dx", int'(dut.dx_q), 1022);
        chk("async_dy", int'(dut.dy_q), 2);
        m = mreset(H, V); mc = mreset(CH, CV);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        frame(0, 0, 1);
        frame(0, 0, 0);
        chk("post_reset_move", int'(dut.ball_x_q), 314);

        // corner bounce on the wide-field instance
        pixel_x = 10'd1; pixel_y = 10'd0;
        ctick(1);
        repeat (234) ctick(0);
        chk("corner_x", int'(dut_c.ball_x_q), 36);
        chk("corner_y", int'(dut_c.ball_y_q), 6);
        ctick(0);
        chk("corner_next_x", int'(dut_c.ball_x_q), 38);
        chk("corner_next_y", int'(dut_c.ball_y_q), 8);
        chk("corner_dx", int'(dut_c.dx_q), 2);
        chk("corner_dy", int'(dut_c.dy_q), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
